// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: widths, FSM state
// encodings, requester IDs and a small alignment helper.
package dmem_port_arbiter_pkg;

    localparam int WORD  = 32;
    localparam int BYTE  = 8;
    localparam int CNT_W = 3;   // enough for LAT up to 7

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t ST_IDLE   = 2'd0;
    localparam dmem_state_t ST_ACCESS = 2'd1;
    localparam dmem_state_t ST_RESP   = 2'd2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    // A word access is aligned only when the two byte-select bits are zero.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side handshake bundle. One instance per requester (MEM stage,
// loader). The requester uses the master modport, the arbiter the slave.
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          done;
    logic          err;
    logic          stall;

    modport master (output req, we, addr, wdata, input rdata, done, err, stall);
    modport slave  (input req, we, addr, wdata, output rdata, done, err, stall);
endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer. The pointer resets to
// the loader so the CPU wins the first contended grant.
module dmem_rr_arb2
    import dmem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,      // bit REQ_CPU / bit REQ_LDR
    input  logic       take,     // grant is consumed this cycle
    output logic       gnt_vld,
    output logic       gnt_id
);
    logic last;

    // A lone requester wins; on contention the side not served last wins.
    always_comb begin
        gnt_vld = |req;
        gnt_id  = REQ_CPU;
        if (req[REQ_CPU] && req[REQ_LDR])
            gnt_id = ~last;
        else if (req[REQ_LDR])
            gnt_id = REQ_LDR;
    end

    // Remember who was served so the other side is favoured next time.
    always_ff @(posedge clk) begin
        if (rst)
            last <= REQ_LDR;
        else if (take && gnt_vld)
            last <= gnt_id;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage and the
// loader. Each transaction runs IDLE -> ACCESS (LAT cycles) -> RESP -> IDLE;
// the write strobe fires only in the last ACCESS cycle.
// Optional: define DMEM_ALIGN_CHECK_EN to fault misaligned word accesses in
// IDLE (straight to RESP with err, no memory cycle).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2        // legal 1..7
)(
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   cpu,
    dmem_port_arbiter_if.slave   ldr,
    output logic                 mem_w,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             gnt_q;
    logic             we_q;
    logic             err_q;
    logic [DW-1:0]    cpu_rd_q;
    logic [DW-1:0]    ldr_rd_q;

    logic             gnt_vld;
    logic             gnt_id;
    logic             fault;
    logic             g_we;
    logic [AW-1:0]    g_addr;
    logic [DW-1:0]    g_wdata;
    logic             cpu_done;
    logic             ldr_done;

    dmem_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({ldr.req, cpu.req}),
        .take    (state == ST_IDLE),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // Select the granted requester's command fields for latching.
    always_comb begin
        g_we    = cpu.we;
        g_addr  = cpu.addr;
        g_wdata = cpu.wdata;
        if (gnt_id == REQ_LDR) begin
            g_we    = ldr.we;
            g_addr  = ldr.addr;
            g_wdata = ldr.wdata;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] gnt_lsb;
    assign gnt_lsb = (gnt_id == REQ_LDR) ? ldr.addr[1:0] : cpu.addr[1:0];
    assign fault   = misaligned(gnt_lsb);
`else
    assign fault   = 1'b0;
`endif

    // Transaction sequencer: grant/latch in IDLE, count out the memory
    // latency in ACCESS, capture read data on the strobe cycle, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gnt_q     <= REQ_CPU;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rd_q  <= '0;
            ldr_rd_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        gnt_q     <= gnt_id;
                        we_q      <= g_we;
                        mem_addr  <= g_addr;
                        mem_wdata <= g_wdata;
                        cnt       <= CNT_LOAD;
                        err_q     <= fault;
                        state     <= fault ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            if (gnt_q == REQ_LDR) ldr_rd_q <= mem_rdata;
                            else                  cpu_rd_q <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Single write strobe on the final ACCESS cycle; a reset in that cycle
    // suppresses it so an interrupted write never lands.
    assign mem_w = (state == ST_ACCESS) && (cnt == '0) && we_q && !rst;
    assign busy  = (state != ST_IDLE);

    assign cpu_done  = (state == ST_RESP) && (gnt_q == REQ_CPU);
    assign ldr_done  = (state == ST_RESP) && (gnt_q == REQ_LDR);

    assign cpu.done  = cpu_done;
    assign ldr.done  = ldr_done;
    assign cpu.err   = cpu_done & err_q;
    assign ldr.err   = ldr_done & err_q;
    assign cpu.rdata = cpu_rd_q;
    assign ldr.rdata = ldr_rd_q;
    assign cpu.stall = cpu.req & ~cpu_done;
    assign ldr.stall = ldr.req & ~ldr_done;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a random
// two-requester phase, all checked against a transaction-timeline model.
module tb_dmem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) cpu ();
    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) ldr ();

    dmem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu),
        .ldr       (ldr),
        .mem_w     (mem_w),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // 256-byte big-endian memory driven by the DUT; ref_mem is the model copy.
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    assign mem_rdata = {mem[mem_addr[7:0]], mem[8'(mem_addr[7:0] + 8'd1)],
                        mem[8'(mem_addr[7:0] + 8'd2)], mem[8'(mem_addr[7:0] + 8'd3)]};

    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_addr[7:0]]              <= mem_wdata[31:24];
            mem[8'(mem_addr[7:0] + 8'd1)]   <= mem_wdata[23:16];
            mem[8'(mem_addr[7:0] + 8'd2)]   <= mem_wdata[15:8];
            mem[8'(mem_addr[7:0] + 8'd3)]   <= mem_wdata[7:0];
        end
    end

    function automatic logic [31:0] ref_rd(input logic [7:0] a);
        return {ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd3)]};
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model: a granted transaction occupies phases 0 (IDLE grant
    // cycle) .. end; strobe/capture at phase LAT, done at LAT+1 (1 if faulted).
    bit          armed = 0;
    bit          m_act = 0, m_side = 0, m_we = 0, m_fault = 0, m_last = 1;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] m_rd [2];
    int          m_ph = 0;
    int          cyc = 0;
    int          mw_cnt = 0;
    int          done_side_q[$];
    int          done_cyc_q[$];

    always @(negedge clk) begin
        if (armed) begin
            if (mem_w) mw_cnt++;
            if (rst) begin
                chk("mw_in_rst", mem_w, 0);
                m_act = 0; m_last = 1; m_rd[0] = '0; m_rd[1] = '0;
            end else begin
                int  endph;
                bit  e_dc, e_dl, e_flt, e_w, e_busy;
                cyc++;
                if (m_act) m_ph++;
                endph  = m_fault ? 1 : LAT + 1;
                e_busy = m_act && m_ph >= 1;
                e_w    = m_act && !m_fault && m_ph == LAT && m_we;
                e_dc   = m_act && m_ph == endph && m_side == 0;
                e_dl   = m_act && m_ph == endph && m_side == 1;
                e_flt  = m_act && m_ph == endph && m_fault;
                chk("busy",      busy,      e_busy);
                chk("mem_w",     mem_w,     e_w);
                chk("cpu_done",  cpu.done,  e_dc);
                chk("ldr_done",  ldr.done,  e_dl);
                chk("cpu_err",   cpu.err,   e_dc && e_flt);
                chk("ldr_err",   ldr.err,   e_dl && e_flt);
                chk("cpu_stall", cpu.stall, cpu.req && !e_dc);
                chk("ldr_stall", ldr.stall, ldr.req && !e_dl);
                chk("cpu_rdata", cpu.rdata, m_rd[0]);
                chk("ldr_rdata", ldr.rdata, m_rd[1]);
                if (m_act && !m_fault && m_ph >= 1 && m_ph <= LAT) begin
                    chk("mem_addr",  mem_addr,  m_addr);
                    chk("mem_wdata", mem_wdata, m_wdata);
                end
                if (cpu.done) begin done_side_q.push_back(0); done_cyc_q.push_back(cyc); end
                if (ldr.done) begin done_side_q.push_back(1); done_cyc_q.push_back(cyc); end
                if (m_act && !m_fault && m_ph == LAT) begin
                    if (m_we) begin
                        ref_mem[m_addr[7:0]]            = m_wdata[31:24];
                        ref_mem[8'(m_addr[7:0] + 8'd1)] = m_wdata[23:16];
                        ref_mem[8'(m_addr[7:0] + 8'd2)] = m_wdata[15:8];
                        ref_mem[8'(m_addr[7:0] + 8'd3)] = m_wdata[7:0];
                    end else begin
                        m_rd[m_side] = ref_rd(m_addr[7:0]);
                    end
                end
                if (m_act && m_ph == endph) begin
                    m_act = 0;
                end else if (!m_act && (cpu.req || ldr.req)) begin
                    m_side  = (cpu.req && ldr.req) ? !m_last : ldr.req;
                    m_last  = m_side;
                    m_we    = m_side ? ldr.we    : cpu.we;
                    m_addr  = m_side ? ldr.addr  : cpu.addr;
                    m_wdata = m_side ? ldr.wdata : cpu.wdata;
                    m_fault = ALIGN && (m_addr[1:0] != 2'b00);
                    m_act   = 1;
                    m_ph    = 0;
                end
            end
        end
    end

    task automatic drv(input bit side, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
        if (side) begin
            ldr.req = req; ldr.we = we; ldr.addr = addr; ldr.wdata = wdata;
        end else begin
            cpu.req = req; cpu.we = we; cpu.addr = addr; cpu.wdata = wdata;
        end
    endtask

    // Call just after a posedge; returns just after the posedge ending RESP.
    task automatic do_txn(input bit side, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold,
                          output int lat, output logic [31:0] rdata, output bit err);
        bit seen = 0;
        lat = -1; rdata = '0; err = 0;
        drv(side, 1'b1, we, addr, wdata);
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (side ? ldr.done : cpu.done) begin
                seen  = 1;
                lat   = n;
                rdata = side ? ldr.rdata : cpu.rdata;
                err   = side ? ldr.err : cpu.err;
            end
        end
        chk("done_seen", seen, 1);
        @(posedge clk); #2;
        if (!hold) drv(side, 1'b0, we, addr, wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, qs, m0, d0, nb;
        logic [31:0] rd, orig, prev;
        bit          er;

        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[16] <= 8'hDE; mem[17] <= 8'hAD; mem[18] <= 8'hBE; mem[19] <= 8'hEF;
        ref_mem[16] = 8'hDE; ref_mem[17] = 8'hAD; ref_mem[18] = 8'hBE; ref_mem[19] = 8'hEF;
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);
        rst = 1'b1;
        @(posedge clk); #2;
        armed = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_busy",  busy,      0);
        chk("rst_memw",  mem_w,     0);
        chk("rst_addr",  mem_addr,  0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_crd",   cpu.rdata, 0);
        chk("rst_lrd",   ldr.rdata, 0);
        chk("rst_cdone", cpu.done,  0);
        chk("rst_ldone", ldr.done,  0);

        // 1: cpu read of DEADBEEF
        @(posedge clk); #2;
        do_txn(0, 0, 32'h10, '0, 0, lat, rd, er);
        chk("t1_lat", lat, LAT + 1);
        chk("t1_rd",  rd,  32'hDEADBEEF);
        chk("t1_err", er,  0);

        // 2: loader write then cpu readback
        m0 = mw_cnt;
        do_txn(1, 1, 32'h20, 32'h12345678, 0, lat, rd, er);
        chk("t2_wcnt", mw_cnt - m0, 1);
        do_txn(0, 0, 32'h20, '0, 0, lat, rd, er);
        chk("t2_rd", rd, 32'h12345678);

        // 3: both held from reset -> cpu, ldr, cpu, ldr
        rst = 1'b1;
        drv(0, 1, 0, 32'h10, '0);
        drv(1, 1, 0, 32'h20, '0);
        @(posedge clk); #2 rst = 1'b0;
        qs = done_side_q.size();
        fork
            begin
                int l; logic [31:0] r; bit e;
                do_txn(0, 0, 32'h10, '0, 1, l, r, e);
                chk("t3_c0", r, 32'hDEADBEEF);
                do_txn(0, 1, 32'h30, 32'hA5A55A5A, 0, l, r, e);
            end
            begin
                int l; logic [31:0] r; bit e;
                do_txn(1, 0, 32'h20, '0, 1, l, r, e);
                chk("t3_l0", r, 32'h12345678);
                do_txn(1, 0, 32'h30, '0, 0, l, r, e);
                chk("t3_l1", r, 32'hA5A55A5A);
            end
        join
        for (int i = 0; i < 4; i++) chk("t3_order", done_side_q[qs + i], i % 2);
        for (int i = 1; i < 4; i++)
            chk("t3_space", done_cyc_q[qs + i] - done_cyc_q[qs + i - 1], LAT + 2);

        // 4: reset in first ACCESS cycle of a cpu write
        orig = {mem[64], mem[65], mem[66], mem[67]};
        drv(0, 1, 1, 32'h40, 32'hCAFEF00D);
        @(posedge clk); #2;
        rst = 1'b1;
        drv(0, 0, 0, '0, '0);
        m0 = mw_cnt;
        d0 = done_side_q.size();
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("t4_wcnt", mw_cnt - m0, 0);
        chk("t4_done", done_side_q.size() - d0, 0);
        chk("t4_mem", {mem[64], mem[65], mem[66], mem[67]}, orig);

        // 5: cpu_req dropped after one ACCESS cycle
        @(posedge clk); #2;
        d0 = done_side_q.size();
        drv(0, 1, 0, 32'h10, '0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        drv(0, 0, 0, '0, '0);
        repeat (8) @(negedge clk);
        chk("t5_done", done_side_q.size() - d0, 1);
        chk("t5_busy", busy, 0);

        // 6: misaligned cpu read
        @(posedge clk); #2;
        prev = m_rd[0];
        m0 = mw_cnt;
        do_txn(0, 0, 32'h13, '0, 0, lat, rd, er);
        chk("t6_lat", lat, ALIGN ? 1 : LAT + 1);
        chk("t6_err", er, ALIGN);
        chk("t6_rd",  rd, ALIGN ? prev : ref_rd(8'h13));
        chk("t6_mw",  mw_cnt - m0, 0);

        // random two-requester traffic
        fork
            for (int i = 0; i < 40; i++) begin
                int l; logic [31:0] r, a; bit e;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                a = $urandom;
                if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                do_txn(0, 1'($urandom_range(0, 1)), a, $urandom, 0, l, r, e);
            end
            for (int j = 0; j < 40; j++) begin
                int l; logic [31:0] r, a; bit e;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                a = $urandom;
                if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                do_txn(1, 1'($urandom_range(0, 1)), a, $urandom, 0, l, r, e);
            end
        join
        repeat (4) @(negedge clk);

        nb = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nb++;
        chk("mem_image", nb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
